// File: rtl/hbs_mac.sv
// hbs_mac: precision-scalable signed/unsigned multiply-accumulate. It has a three-stage pipeline
// (products, dot-product reduction, accumulate) and valid/ready flow control on both sides.
module hbs_mac #(
   parameter int unsigned LANE_W = 4,
   parameter int unsigned NUM    = 4,
   parameter int unsigned ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               mode,
   input  logic                     sign_en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [LANE_W*NUM-1:0]    mult0,
   input  logic [LANE_W*NUM-1:0]    mult1,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         result,
   output logic                     overflow
);

   localparam int unsigned W      = LANE_W * NUM;
   localparam int unsigned XW     = W + 1;
   localparam int unsigned PROD_W = 2 * W + 2;
   localparam int unsigned SUM_W  = PROD_W + $clog2(NUM);

   // Extract sub-word k of width s. Return it zero- or sign-extended to W+1 bits.
   function automatic logic [W:0] sub_ext(input logic [W-1:0] x, input int unsigned s,
                                          input int unsigned k, input logic sgn);
      logic [W:0] sh;
      logic [W:0] mask;
      logic       msb;
      sh   = {1'b0, x >> (k * s)};
      mask = (XW'(1) << s) - XW'(1);
      msb  = sgn && ((sh & (mask ^ (mask >> 1))) != '0);
      return msb ? (sh | ~mask) : (sh & mask);
   endfunction

   logic [NUM-1:0][PROD_W-1:0] prod_q, prod_d, prod_c;
   logic                       v1_q, v1_d, last1_q, last1_d, sgn1_q, sgn1_d;
   logic [ACC_W-1:0]           val2_q, val2_d;
   logic                       v2_q, v2_d, last2_q, last2_d, sgn2_q, sgn2_d;
   logic [ACC_W-1:0]           acc_q, acc_d, result_q, result_d;
   logic                       first_q, first_d, sticky_q, sticky_d;
   logic                       ovf_q, ovf_d, out_valid_q, out_valid_d;

   logic                       stall;
   int unsigned                sw, cnt;
   logic signed [PROD_W-1:0]   ea, eb;
   logic signed [SUM_W-1:0]    dot;
   logic [ACC_W-1:0]           acc_sum, acc_new;
   logic                       carry, beat_ovf, sticky_new;

   // A last beat in flight must not overwrite a result that downstream has not accepted yet.
   assign stall    = out_valid_q && !out_ready && ((v1_q && last1_q) || (v2_q && last2_q));
   assign in_ready = !stall;

   // Form one sub-word product per lane for the selected width. Reserved mode gives zeros.
   always_comb begin
      sw     = W;
      cnt    = 1;
      ea     = '0;
      eb     = '0;
      prod_c = '0;
      case (mode)
         2'b00:   begin sw = LANE_W;     cnt = NUM;     end
         2'b01:   begin sw = 2 * LANE_W; cnt = NUM / 2; end
         default: ;
      endcase
      for (int unsigned k = 0; k < NUM; k++) begin
         if (k < cnt && mode != 2'b11) begin
            ea        = PROD_W'($signed(sub_ext(mult0, sw, k, sign_en)));
            eb        = PROD_W'($signed(sub_ext(mult1, sw, k, sign_en)));
            prod_c[k] = ea * eb;
         end
      end
   end

   always_comb begin
      dot = '0;
      for (int unsigned k = 0; k < NUM; k++) dot = dot + SUM_W'($signed(prod_q[k]));
   end

   always_comb begin
      {carry, acc_sum} = {1'b0, acc_q} + {1'b0, val2_q};
      beat_ovf   = sgn2_q ? ((acc_q[ACC_W-1] == val2_q[ACC_W-1]) &&
                             (acc_sum[ACC_W-1] != acc_q[ACC_W-1])) : carry;
      acc_new    = first_q ? val2_q : acc_sum;
      sticky_new = first_q ? 1'b0 : (sticky_q | beat_ovf);
   end

   always_comb begin
      prod_d      = prod_q;
      v1_d        = v1_q;
      last1_d     = last1_q;
      sgn1_d      = sgn1_q;
      val2_d      = val2_q;
      v2_d        = v2_q;
      last2_d     = last2_q;
      sgn2_d      = sgn2_q;
      acc_d       = acc_q;
      first_d     = first_q;
      sticky_d    = sticky_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q && !out_ready;
      if (!stall) begin
         prod_d  = prod_c;
         v1_d    = in_valid;
         last1_d = in_last;
         sgn1_d  = sign_en;
         val2_d  = ACC_W'(dot);
         v2_d    = v1_q;
         last2_d = last1_q;
         sgn2_d  = sgn1_q;
         if (v2_q) begin
            acc_d    = acc_new;
            sticky_d = sticky_new;
            first_d  = last2_q;
            if (last2_q) begin
               result_d    = acc_new;
               ovf_d       = sticky_new;
               out_valid_d = 1'b1;
               sticky_d    = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q      <= '0;
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         sgn1_q      <= 1'b0;
         val2_q      <= '0;
         v2_q        <= 1'b0;
         last2_q     <= 1'b0;
         sgn2_q      <= 1'b0;
         acc_q       <= '0;
         first_q     <= 1'b1;
         sticky_q    <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         prod_q      <= prod_d;
         v1_q        <= v1_d;
         last1_q     <= last1_d;
         sgn1_q      <= sgn1_d;
         val2_q      <= val2_d;
         v2_q        <= v2_d;
         last2_q     <= last2_d;
         sgn2_q      <= sgn2_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         sticky_q    <= sticky_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_hbs_mac.sv
// tb_hbs_mac: scoreboard bench for hbs_mac. A default (ACC_W=40) instance and an ACC_W=33 instance
// receive the same stimulus.
module tb_hbs_mac;

   typedef struct {
      logic [39:0] r40;
      logic        o40;
      logic [32:0] r33;
      logic        o33;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic        sign_en, in_valid, in_last, out_ready;
   logic [15:0] mult0, mult1;
   logic        in_ready_a, out_valid_a, overflow_a;
   logic        in_ready_b, out_valid_b, overflow_b;
   logic [39:0] result_a;
   logic [32:0] result_b;

   int          checks = 0;
   int          errors = 0;
   sb_t         sb[$];
   sb_t         mon_e;

   logic        m_first;
   logic [63:0] m_acc40, m_acc33;
   logic        m_ovf40, m_ovf33;

   always #5 clk = ~clk;

   hbs_mac dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sign_en(sign_en), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_last(in_last), .mult0(mult0), .mult1(mult1),
      .out_valid(out_valid_a), .out_ready(out_ready), .result(result_a), .overflow(overflow_a)
   );

   hbs_mac #(.LANE_W(4), .NUM(4), .ACC_W(33)) dut33 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sign_en(sign_en), .in_valid(in_valid),
      .in_ready(in_ready_b), .in_last(in_last), .mult0(mult0), .mult1(mult1),
      .out_valid(out_valid_b), .out_ready(out_ready), .result(result_b), .overflow(overflow_b)
   );

   function automatic longint beat_val(input logic [1:0] m, input logic s,
                                       input logic [15:0] a, input logic [15:0] b);
      int     sw;
      longint sum, x, y, msk;
      sum = 0;
      case (m)
         2'b00:   sw = 4;
         2'b01:   sw = 8;
         2'b10:   sw = 16;
         default: sw = 0;
      endcase
      if (sw == 0) return 0;
      msk = (longint'(1) << sw) - 1;
      for (int k = 0; k < 16 / sw; k++) begin
         x = (longint'(a) >> (k * sw)) & msk;
         y = (longint'(b) >> (k * sw)) & msk;
         if (s && x[sw-1]) x = x - (msk + 1);
         if (s && y[sw-1]) y = y - (msk + 1);
         sum = sum + x * y;
      end
      return sum;
   endfunction

   function automatic void step(input int w, input longint v, input logic s, input logic [63:0] acc,
                                output logic [63:0] acc_n, output logic bo);
      logic [63:0] mask, vm, sum;
      mask = (64'd1 << w) - 64'd1;
      vm   = 64'(v) & mask;
      sum  = acc + vm;
      if (s) bo = (acc[w-1] == vm[w-1]) && (sum[w-1] != acc[w-1]);
      else   bo = sum[w];
      acc_n = sum & mask;
   endfunction

   task automatic model_reset();
      sb.delete();
      m_first = 1'b1;
      m_acc40 = '0;
      m_acc33 = '0;
      m_ovf40 = 1'b0;
      m_ovf33 = 1'b0;
   endtask

   task automatic model_accept(input logic [1:0] m, input logic s, input logic [15:0] a,
                               input logic [15:0] b, input logic last);
      longint      v;
      logic [63:0] n40, n33;
      logic        b40, b33;
      sb_t         e;
      v = beat_val(m, s, a, b);
      if (m_first) begin
         m_acc40 = 64'(v) & ((64'd1 << 40) - 64'd1);
         m_acc33 = 64'(v) & ((64'd1 << 33) - 64'd1);
         m_ovf40 = 1'b0;
         m_ovf33 = 1'b0;
      end else begin
         step(40, v, s, m_acc40, n40, b40);
         step(33, v, s, m_acc33, n33, b33);
         m_acc40 = n40;
         m_acc33 = n33;
         m_ovf40 = m_ovf40 | b40;
         m_ovf33 = m_ovf33 | b33;
      end
      if (last) begin
         e.r40 = 40'(m_acc40);
         e.o40 = m_ovf40;
         e.r33 = 33'(m_acc33);
         e.o33 = m_ovf33;
         sb.push_back(e);
      end
      m_first = last;
   endtask

   task automatic send(input logic [1:0] m, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic last);
      int n;
      n = 0;
      mode = m; sign_en = s; mult0 = a; mult1 = b; in_last = last; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready_a && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready_a) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready_a);
      end else begin
         model_accept(m, s, a, b, last);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      mult0    = 16'($urandom);
      mult1    = 16'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid_a && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!out_valid_a) begin
         errors++;
         $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid_a);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   // Scoreboard monitor: a result transfers on the edge after a negedge with valid && ready.
   always @(negedge clk) begin
      if (rst_n && out_valid_a && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: unexpected result %h", result_a);
         end else begin
            mon_e = sb.pop_front();
            if (result_a !== mon_e.r40 || overflow_a !== mon_e.o40) begin
               errors++;
               $display("FAIL result40: got %h ovf %0b, required %h ovf %0b",
                        result_a, overflow_a, mon_e.r40, mon_e.o40);
            end
            checks++;
            if (out_valid_b !== 1'b1 || result_b !== mon_e.r33 || overflow_b !== mon_e.o33) begin
               errors++;
               $display("FAIL result33: got v%0b %h ovf %0b, required v1 %h ovf %0b",
                        out_valid_b, result_b, overflow_b, mon_e.r33, mon_e.o33);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; mode = 2'b00; sign_en = 1'b0;
      mult0 = '0; mult1 = '0; out_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || result_a !== 40'd0 || overflow_a !== 1'b0 || in_ready_a !== 1'b1) begin
         errors++;
         $display("FAIL reset_a: v%0b r%h o%0b rdy%0b, required v0 r0 o0 rdy1",
                  out_valid_a, result_a, overflow_a, in_ready_a);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid_b !== 1'b0 || result_b !== 33'd0 || overflow_b !== 1'b0 || in_ready_b !== 1'b1) begin
         errors++;
         $display("FAIL reset_b: v%0b r%h o%0b rdy%0b, required v0 r0 o0 rdy1",
                  out_valid_b, result_b, overflow_b, in_ready_b);
      end
   endtask

   task automatic test_latency();
      logic [2:0] seen;
      send(2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      seen[0] = out_valid_a;
      @(posedge clk); #1; seen[1] = out_valid_a;
      @(posedge clk); #1; seen[2] = out_valid_a;
      checks++;
      if (seen !== 3'b100) begin
         errors++;
         $display("FAIL latency: out_valid after E0..E2 = %b, required 100", seen);
      end
      checks++;
      if (result_a !== 40'h00FFFE0001) begin
         errors++;
         $display("FAIL ffff_sq: got %h, required 00fffe0001", result_a);
      end
      wait_drain();
   endtask

   task automatic test_modes();
      send(2'b01, 1'b0, 16'h0302, 16'h0504, 1'b1);
      send(2'b00, 1'b1, 16'hF123, 16'h2222, 1'b1);
      send(2'b10, 1'b1, 16'hFFFF, 16'h0002, 1'b1);
      send(2'b11, 1'b1, 16'h1234, 16'h5678, 1'b1);
      send(2'b01, 1'b1, 16'h80FF, 16'h7F01, 1'b1);
      wait_drain();
   endtask

   task automatic test_burst();
      send(2'b00, 1'b0, 16'h1111, 16'h1111, 1'b0);
      send(2'b01, 1'b0, 16'h0101, 16'h0202, 1'b0);
      send(2'b10, 1'b0, 16'h0002, 16'h0003, 1'b1);
      wait_drain();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 3; i++) send(2'b10, 1'b0, 16'hFFFF, 16'hFFFF, i == 2);
      send(2'b10, 1'b0, 16'h0001, 16'h0001, 1'b1);
      for (int i = 0; i < 5; i++) send(2'b10, 1'b1, 16'h8000, 16'h8000, i == 4);
      send(2'b10, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int len;
      for (int i = 0; i < 12; i++) begin
         len = $urandom_range(1, 4);
         for (int j = 0; j < len; j++)
            send(2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), j == len - 1);
      end
      wait_drain();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(2'b10, 1'b0, 16'd3, 16'd5, 1'b1);
      wait_out_valid();
      send(2'b10, 1'b0, 16'd2, 16'd2, 1'b0);
      send(2'b10, 1'b0, 16'd3, 16'd3, 1'b1);
      checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || result_a !== 40'd15) begin
         errors++;
         $display("FAIL stall_enter: rdy%0b v%0b r%h, required rdy0 v1 r0f",
                  in_ready_a, out_valid_a, result_a);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || result_a !== 40'd15) begin
         errors++;
         $display("FAIL stall_hold: rdy%0b v%0b r%h, required rdy0 v1 r0f",
                  in_ready_a, out_valid_a, result_a);
      end
      fork
         send(2'b10, 1'b0, 16'd1, 16'd1, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      send(2'b10, 1'b0, 16'd4, 16'd1, 1'b1);
      wait_drain();
   endtask

   task automatic test_reset_mid_burst();
      out_ready = 1'b0;
      send(2'b10, 1'b0, 16'd7, 16'd1, 1'b1);
      wait_out_valid();
      send(2'b10, 1'b0, 16'd9, 16'd9, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || result_a !== 40'd0 || overflow_a !== 1'b0 || in_ready_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: v%0b r%h o%0b rdy%0b, required v0 r0 o0 rdy1",
                  out_valid_a, result_a, overflow_a, in_ready_a);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(2'b10, 1'b0, 16'd2, 16'd3, 1'b1);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_modes();
      test_burst();
      test_overflow();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_burst();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/hbs_mac.md
Name: hbs_mac

Overview:
- Parametrised, precision-scalable multiply-accumulate unit. Successor to the fixed 16-bit, 4/8/16-mode bit-scalable multiplier.
- Operands are split into sub-words according to a per-beat mode. Sub-word products are reduced to a dot product and accumulated across a burst that is delimited by in_last.
- Adds over the previous generation: signed operands, accumulation, valid/ready handshake with back-pressure, and an overflow flag.
- Sits between the operand-fetch stream and the result writeback FIFO of the compute array.

Parameters:
- LANE_W, 4, minimum sub-word width in bits.
- NUM, 4, lanes per operand; operand width W = LANE_W*NUM. NUM is a power of two, ≥2.
- ACC_W, 40, accumulator/result width; must be ≥ 2*W+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  sub-word width per beat: 00 = LANE_W, 01 = 2*LANE_W, 10 = W, 11 = reserved.
- sign_en  in  1  1 = sub-words are two's complement; 0 = unsigned. Sampled per beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of an accumulation burst.
- mult0  in  W  operand A.
- mult1  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  ACC_W  accumulated dot product; sign-extended when sign_en.
- overflow  out  1  burst accumulator overflowed; qualified by out_valid.

Behaviour:
- Reset state: all pipeline registers cleared. out_valid=0, result=0, overflow=0, accumulator=0, in_ready=1.
- Reset asserted mid-burst discards the burst, including any pending result.
- Sub-word width S by mode: 00 → LANE_W, 01 → 2*LANE_W, 10 → W. Count K = W/S.
- Beat value = sum over k<K of A[k]*B[k], where A[k] = mult0[(k+1)*S-1 : k*S] and likewise B[k] from mult1.
  - sign_en=1: each sub-word is interpreted signed.
  - sign_en=0: each sub-word is interpreted unsigned.
  - The sum is formed exactly, then extended to ACC_W.
- mode=11: the beat is accepted normally, contributes value 0, and in_last is still honoured.
- Pipeline on accept edge E0:
  - E0: sub-word products registered, together with mode, sign_en and last.
  - E1: dot-product reduction registered.
  - E2: accumulator updated.
- Accumulate rule at E2:
  - If the beat is the first of a burst (first beat after reset or after a last beat), acc = value.
  - Otherwise acc = acc + value, computed modulo 2^ACC_W.
- Last beat at E2: result <= new acc, overflow <= sticky burst flag, out_valid <= 1. The internal accumulator returns to the first-of-burst condition.
- Latency: a last beat accepted on edge E0 gives out_valid=1 in the cycle after E2 (3 edges).
- Overflow detection:
  - Unsigned: carry out of ACC_W.
  - Signed: operands same sign, sum of different sign.
  - The flag is sticky for the whole burst and clears at the start of the next burst.
  - Mode and sign_en may change mid-burst. Overflow follows the sign_en of each beat.
- Output handshake: result/out_valid hold stable while out_valid && !out_ready. out_valid drops on the edge where out_ready=1, unless a new last beat completes on that same edge; then it stays 1 with the new result.
- Back-pressure: stall = out_valid && !out_ready && (a last beat occupies E1 or E2).
  - During a stall, in_ready=0 and all pipeline stages hold.
  - Non-last beats continue to accumulate while the result waits, provided no last beat would overwrite the held result.
- No bubbles are required. Full throughput is 1 beat/cycle when out_ready=1.
- Signals are sampled only when in_valid && in_ready; mult0/mult1 are ignored otherwise.

Test Plan:
- Mode 10, sign_en=0, mult0=mult1=0xFFFF, in_last=1 → result=0x00FFFE0001, overflow=0, out_valid exactly 3 edges after accept.
- Mode 01, unsigned, mult0=0x0302, mult1=0x0504, last → result=23 (3*5+2*4).
- Mode 00, signed, mult0=0xF123, mult1=0x2222, last → result=10 (-2+2+4+6).
- Burst of 3 beats: mode 00 unsigned 0x1111·0x1111 (=4), then mode 01 0x0101·0x0202 (=4), then mode 10 0x0002·0x0003 (=6) with last → 14. Mixed modes accumulate correctly.
- ACC_W=33, mode 10 unsigned, three beats of 0xFFFF·0xFFFF, last on the third → result=0x0FFFA0003, overflow=1. The next single-beat burst 1·1 → result=1, overflow=0.
- Back-pressure and reset:
  - Hold out_ready=0 with a result pending while a second burst's last beat reaches E1 → in_ready=0, first result stable.
  - Release out_ready → second result follows with no beat lost.
  - Asserting rst_n=0 mid-burst → all outputs 0 immediately; the next burst starts from zero.
